// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA timing generator and pixel FIFO consumer with SOF resynchronisation.
// Optional statistics counters are built only when VGA_SCANOUT_STAT_EN is defined.
module vga_scanout #(
    parameter int DATA_WIDTH = 25,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_vld,
    output logic                  fifo_rdy,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_aempty,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic                  vga_de,
    output logic [DATA_WIDTH-2:0] vga_rgb,
    output logic                  frame_start,
    output logic                  underrun,
    input  logic                  underrun_clr,
    output logic [15:0]           underrun_cnt,
    output logic [15:0]           frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    typedef enum logic [1:0] {IDLE, SYNC, RUN, RESYNC} state_t;

    state_t                state_q;
    logic [HW-1:0]         h_q;
    logic [VW-1:0]         v_q;
    logic                  hsync_q, vsync_q, de_q, fs_q, underrun_q;
    logic [DATA_WIDTH-2:0] rgb_q;

    logic sof, running, active, origin, h_last, frame_last;
    logic px_ok, px_err, hs_on, vs_on;
    logic hsync_d, vsync_d, de_d, fs_d;
    logic [DATA_WIDTH-2:0] rgb_d;

    assign sof        = fifo_data[DATA_WIDTH-1];
    assign running    = (state_q == RUN) || (state_q == RESYNC);
    assign active     = (h_q < H_ACT) && (v_q < V_ACT);
    assign origin     = (h_q == '0) && (v_q == '0);
    assign h_last     = (h_q == H_LAST);
    assign frame_last = h_last && (v_q == V_LAST);
    assign hs_on      = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs_on      = (v_q >= VS_BEG) && (v_q < VS_END);

    // A good pixel needs data present and SOF exactly at the origin; anything else is an error.
    assign px_ok  = (state_q == RUN) && active && fifo_vld && (sof == origin);
    assign px_err = (state_q == RUN) && active && !(fifo_vld && (sof == origin));

    always_comb begin
        fifo_rdy = 1'b0;
        case (state_q)
            SYNC, RESYNC: fifo_rdy = fifo_vld && !sof;
            RUN:          fifo_rdy = px_ok;
            default:      fifo_rdy = 1'b0;
        endcase
    end

    always_comb begin
        hsync_d = (running && hs_on) ? HSYNC_POL : !HSYNC_POL;
        vsync_d = (running && vs_on) ? VSYNC_POL : !VSYNC_POL;
        de_d    = (state_q == RUN) && active;
        rgb_d   = px_ok ? fifo_data[DATA_WIDTH-2:0] : '0;
        fs_d    = px_ok && origin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            h_q        <= '0;
            v_q        <= '0;
            hsync_q    <= !HSYNC_POL;
            vsync_q    <= !VSYNC_POL;
            de_q       <= 1'b0;
            rgb_q      <= '0;
            fs_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (running) begin
                h_q <= h_last ? '0 : h_q + 1'b1;
                if (h_last) v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_q <= '0;
                v_q <= '0;
            end

            case (state_q)
                IDLE:    if (en) state_q <= SYNC;
                SYNC: begin
                    if (!en)                                  state_q <= IDLE;
                    else if (fifo_vld && sof && !fifo_aempty) state_q <= RUN;
                end
                RUN: begin
                    if (frame_last && !en) state_q <= IDLE;
                    else if (px_err)       state_q <= RESYNC;
                end
                RESYNC: begin
                    if (frame_last) begin
                        if (!en)                 state_q <= IDLE;
                        else if (fifo_vld && sof) state_q <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase

            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
            fs_q    <= fs_d;

            if (px_err)            underrun_q <= 1'b1;
            else if (underrun_clr) underrun_q <= 1'b0;
        end
    end

    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_de      = de_q;
    assign vga_rgb     = rgb_q;
    assign frame_start = fs_q;
    assign underrun    = underrun_q;

`ifdef VGA_SCANOUT_STAT_EN
    logic [15:0] ucnt_q, fcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ucnt_q <= '0;
            fcnt_q <= '0;
        end else begin
            if (px_err && (ucnt_q != 16'hFFFF))         ucnt_q <= ucnt_q + 16'd1;
            if (px_ok && origin && (fcnt_q != 16'hFFFF)) fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign underrun_cnt = ucnt_q;
    assign frame_cnt    = fcnt_q;
`else
    assign underrun_cnt = 16'h0;
    assign frame_cnt    = 16'h0;
`endif

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - directed bench for vga_scanout on an 8x6 timing with a queue-modelled FIFO.
module tb_vga_scanout;
    localparam int DW = 9;
    localparam int HT = 8;
`ifdef VGA_SCANOUT_STAT_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, en, fifo_vld, fifo_rdy, fifo_aempty;
    logic [DW-1:0] fifo_data;
    logic          vga_hsync, vga_vsync, vga_de, frame_start, underrun, underrun_clr;
    logic [DW-2:0] vga_rgb;
    logic [15:0]   underrun_cnt, frame_cnt;

    vga_scanout #(
        .DATA_WIDTH(DW),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .fifo_vld(fifo_vld), .fifo_rdy(fifo_rdy), .fifo_data(fifo_data), .fifo_aempty(fifo_aempty),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de), .vga_rgb(vga_rgb),
        .frame_start(frame_start), .underrun(underrun), .underrun_clr(underrun_clr),
        .underrun_cnt(underrun_cnt), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] q[$];
    logic          vld_mask;
    logic          pop;
    int            npop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        fifo_vld    = vld_mask && (q.size() > 0);
        fifo_data   = (q.size() > 0) ? q[0] : '0;
        fifo_aempty = (q.size() < 2);
    endtask

    task automatic tick();
        drive();
        @(negedge clk);
        pop = fifo_vld & fifo_rdy;
        @(posedge clk);
        #1;
        if (pop) begin
            void'(q.pop_front());
            npop++;
        end
        drive();
    endtask

    function automatic logic [DW-1:0] mk(input bit s, input logic [7:0] v);
        return {s, v};
    endfunction

    task automatic load_frame(input logic [7:0] base);
        for (int i = 0; i < 12; i++) q.push_back(mk(i == 0, base + 8'(i)));
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; vld_mask = 1'b1; underrun_clr = 1'b0;
        q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Raise en and wait (bounded) for the frame_start pulse; lat is the tick count.
    task automatic start(output int lat);
        int n;
        en  = 1'b1;
        lat = 99;
        n   = 0;
        while (n < 20) begin
            tick();
            n++;
            if (frame_start === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    function automatic bit exp_de(input int k);
        return ((k % HT) < 4) && ((k / HT) < 3);
    endfunction
    function automatic bit exp_hs(input int k);
        return !(((k % HT) >= 5) && ((k % HT) < 7));
    endfunction
    function automatic bit exp_vs(input int k);
        return !((k / HT) == 4);
    endfunction

    initial begin
        int lat, de_err, hs_err, vs_err, de_cnt, hs_low, vs_low, rgb_ok, p0;

        // Test 1: reset state, then one clean frame
        do_reset();
        check("rst_de", vga_de, 0);
        check("rst_rgb", vga_rgb, 0);
        check("rst_hs", vga_hsync, 1);
        check("rst_vs", vga_vsync, 1);
        check("rst_fs", frame_start, 0);
        check("rst_unr", underrun, 0);
        check("rst_rdy", fifo_rdy, 0);
        check("rst_ucnt", underrun_cnt, 0);
        check("rst_fcnt", frame_cnt, 0);
        load_frame(8'h10);
        load_frame(8'h40);
        npop = 0;
        start(lat);
        check("t1_lat", lat, 3);
        de_err = 0; hs_err = 0; vs_err = 0; de_cnt = 0; hs_low = 0; vs_low = 0; rgb_ok = 0;
        for (int k = 0; k < 48; k++) begin
            if (k > 0) tick();
            if (vga_de !== exp_de(k))    de_err++;
            if (vga_hsync !== exp_hs(k)) hs_err++;
            if (vga_vsync !== exp_vs(k)) vs_err++;
            if (vga_hsync === 1'b0) hs_low++;
            if (vga_vsync === 1'b0) vs_low++;
            if (vga_de === 1'b1) begin
                if (vga_rgb === 8'h10 + 8'(de_cnt)) rgb_ok++;
                de_cnt++;
            end
        end
        check("t1_pops", npop, 12);
        check("t1_de_pat", de_err, 0);
        check("t1_hs_pat", hs_err, 0);
        check("t1_vs_pat", vs_err, 0);
        check("t1_de_cnt", de_cnt, 12);
        check("t1_hs_low", hs_low, 12);
        check("t1_vs_low", vs_low, 8);
        check("t1_rgb_seq", rgb_ok, 12);
        check("t1_fcnt", frame_cnt, STAT);
        tick();
        check("t1_fs2", frame_start, 1);
        check("t1_rgb2", vga_rgb, 8'h40);

        // Test 2: junk ahead of SOF is discarded in SYNC
        do_reset();
        for (int i = 0; i < 3; i++) q.push_back(mk(1'b0, 8'hA0 + 8'(i)));
        load_frame(8'h20);
        npop = 0;
        start(lat);
        check("t2_lat", lat, 6);
        check("t2_disc", npop - 1, 3);
        check("t2_rgb0", vga_rgb, 8'h20);
        check("t2_de0", vga_de, 1);

        // Test 3: underrun at pixel h=1,v=2
        do_reset();
        load_frame(8'h30);
        load_frame(8'h50);
        npop = 0;
        start(lat);
        hs_err = 0; vs_err = 0; de_cnt = 0; p0 = 0;
        for (int k = 1; k < 48; k++) begin
            if (k == 17) vld_mask = 1'b0;
            tick();
            vld_mask = 1'b1;
            if (vga_hsync !== exp_hs(k)) hs_err++;
            if (vga_vsync !== exp_vs(k)) vs_err++;
            if (k == 17) begin
                check("t3_de", vga_de, 1);
                check("t3_rgb", vga_rgb, 0);
                check("t3_unr", underrun, 1);
                check("t3_ucnt", underrun_cnt, STAT);
                check("t3_pre_pops", npop, 9);
                p0 = npop;
            end
            if (k > 17 && vga_de === 1'b1) de_cnt++;
        end
        check("t3_de_after", de_cnt, 0);
        check("t3_discards", npop - p0, 3);
        check("t3_hs_pat", hs_err, 0);
        check("t3_vs_pat", vs_err, 0);
        tick();
        check("t3_fs_next", frame_start, 1);
        check("t3_rgb_next", vga_rgb, 8'h50);

        // Test 4: early SOF at pixel h=3,v=0 with clear held (set wins)
        do_reset();
        check("t4_rst_unr", underrun, 0);
        q.push_back(mk(1'b1, 8'h60));
        q.push_back(mk(1'b0, 8'h61));
        q.push_back(mk(1'b0, 8'h62));
        load_frame(8'h70);
        npop = 0;
        start(lat);
        underrun_clr = 1'b1;
        p0 = 0;
        for (int k = 1; k < 48; k++) begin
            tick();
            if (k == 3) begin
                check("t4_de", vga_de, 1);
                check("t4_rgb", vga_rgb, 0);
                check("t4_unr_setwins", underrun, 1);
                check("t4_pops", npop, 3);
                underrun_clr = 1'b0;
                p0 = npop;
            end
        end
        check("t4_no_pop", npop - p0, 0);
        tick();
        check("t4_fs_next", frame_start, 1);
        check("t4_rgb_next", vga_rgb, 8'h70);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("t4_unr_clr", underrun, 0);
        check("t4_ucnt", underrun_cnt, STAT);

        // Test 5: en dropped mid-frame completes the frame, then IDLE
        do_reset();
        load_frame(8'h80);
        load_frame(8'h90);
        npop = 0;
        start(lat);
        de_cnt = 1;
        for (int k = 1; k < 48; k++) begin
            if (k == 10) en = 1'b0;
            tick();
            if (vga_de === 1'b1) de_cnt++;
        end
        check("t5_de_cnt", de_cnt, 12);
        check("t5_rdy_idle", fifo_rdy, 0);
        p0 = npop; hs_low = 0; vs_low = 0; de_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (vga_hsync !== 1'b1) hs_low++;
            if (vga_vsync !== 1'b1) vs_low++;
            if (vga_de !== 1'b0 || frame_start !== 1'b0) de_cnt++;
        end
        check("t5_hs_idle", hs_low, 0);
        check("t5_vs_idle", vs_low, 0);
        check("t5_de_idle", de_cnt, 0);
        check("t5_pops_idle", npop - p0, 0);

        // Test 6: reset at pixel h=2,v=1
        do_reset();
        load_frame(8'hB0);
        load_frame(8'hC0);
        npop = 0;
        start(lat);
        for (int k = 1; k < 10; k++) tick();
        check("t6_de_pre", vga_de, 1);
        check("t6_rgb_pre", vga_rgb, 8'hB5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_de", vga_de, 0);
        check("t6_rgb", vga_rgb, 0);
        check("t6_hs", vga_hsync, 1);
        check("t6_vs", vga_vsync, 1);
        check("t6_fs", frame_start, 0);
        check("t6_unr", underrun, 0);
        check("t6_rdy", fifo_rdy, 0);
        check("t6_fcnt", frame_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
